comm_mem_responder: RTL and testbench



---
 rtl/comm_mem_responder_pkg.sv | 26 ++
 rtl/comm_mem_responder.sv | 145 ++++++++++++++
 tb/tb_comm_mem_responder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/comm_mem_responder_pkg.sv
// Shared definitions for the memory-request responder: header layout,
// request/response lengths and FSM state encoding.
package comm_mem_responder_pkg;

   // Header (byte 0) bit positions
   localparam int HDR_WRITE  = 0;
   localparam int HDR_SEL_LO = 1;
   localparam int HDR_SEL_HI = 4;
   localparam int HDR_PORT   = 5;
   localparam int HDR_RSVD   = 6;
   localparam int HDR_ERR    = 7;

   // Message lengths in bytes
   localparam logic [4:0] REQ_RD_LEN   = 5'd5;
   localparam logic [4:0] REQ_WR_LEN   = 5'd9;
   localparam logic [4:0] RESP_RD_LEN  = 5'd5;
   localparam logic [4:0] RESP_ACK_LEN = 5'd1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

endpackage

// File: rtl/comm_mem_responder.sv
// Far-end responder for the memory-request protocol: takes one request off
// the channel, performs the word access on a local synchronous RAM and sends
// exactly one response back before accepting the next request.
module comm_mem_responder
   import comm_mem_responder_pkg::*;
#(
   parameter int MESSAGE_BIT = 72,
   parameter int ADDR_WIDTH  = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   comm_readable,
   input  logic [MESSAGE_BIT-1:0] comm_read_data,
   input  logic [4:0]             comm_read_length,
   output logic                   comm_read_flag,
   input  logic                   comm_writable,
   output logic                   comm_write_flag,
   output logic [MESSAGE_BIT-1:0] comm_write_data,
   output logic [4:0]             comm_write_length,
   output logic                   ram_en,
   output logic [3:0]             ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [31:0]            ram_wdata,
   input  logic [31:0]            ram_rdata,
   output logic [7:0]             err_cnt
);

   state_t                 r_state;
   logic [7:0]             r_hdr;
   logic                   r_bad;
   logic                   r_rd_flag;
   logic                   r_wr_flag;
   logic [MESSAGE_BIT-1:0] r_resp_msg;
   logic [4:0]             r_resp_len;
   logic                   r_ram_en;
   logic [3:0]             r_ram_we;
   logic [ADDR_WIDTH-1:0]  r_ram_addr;
   logic [31:0]            r_ram_wdata;
   logic [7:0]             r_err_cnt;

   logic [7:0]             w_hdr;
   logic                   w_is_wr;
   logic                   w_bad;
   logic                   w_unused;

   // Response message: header in byte 0, word in bytes 1-4, rest zero
   function automatic logic [MESSAGE_BIT-1:0] resp_msg(input logic [7:0]  hdr,
                                                       input logic [31:0] word);
      logic [MESSAGE_BIT-1:0] m;
      m       = '0;
      m[7:0]  = hdr;
      m[39:8] = word;
      return m;
   endfunction

   // Error counter increments but sticks at its maximum
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Request decode straight off the channel; legality is resolved before
   // latching so the RAM strobe can be registered and appear in ACCESS.
   assign w_hdr    = comm_read_data[7:0];
   assign w_is_wr  = w_hdr[HDR_WRITE];
   assign w_bad    = w_hdr[HDR_ERR] |
                     (comm_read_length != (w_is_wr ? REQ_WR_LEN : REQ_RD_LEN));
   assign w_unused = ^comm_read_data;

   // Flags are masked by reset so a pulse registered just before reset is
   // never seen by the channel while reset is held.
   assign comm_read_flag    = r_rd_flag & ~rst;
   assign comm_write_flag   = r_wr_flag & ~rst;
   assign comm_write_data   = r_resp_msg;
   assign comm_write_length = r_resp_len;
   assign ram_en            = r_ram_en;
   assign ram_we            = r_ram_we;
   assign ram_addr          = r_ram_addr;
   assign ram_wdata         = r_ram_wdata;
   assign err_cnt           = r_err_cnt;

   // Request/response FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_hdr       <= '0;
         r_bad       <= 1'b0;
         r_rd_flag   <= 1'b0;
         r_wr_flag   <= 1'b0;
         r_resp_msg  <= '0;
         r_resp_len  <= '0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= '0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_rd_flag <= 1'b0;
         r_wr_flag <= 1'b0;
         r_ram_en  <= 1'b0;
         r_ram_we  <= '0;
         case (r_state)
            ST_IDLE: begin
               if (comm_readable) begin
                  r_rd_flag   <= 1'b1;
                  r_hdr       <= w_hdr;
                  r_bad       <= w_bad;
                  // Word address drops the byte offset; upper bits alias
                  r_ram_addr  <= comm_read_data[ADDR_WIDTH+9:10];
                  r_ram_wdata <= comm_read_data[71:40];
                  r_ram_en    <= ~w_bad;
                  r_ram_we    <= (w_is_wr & ~w_bad) ? w_hdr[HDR_SEL_HI:HDR_SEL_LO] : 4'b0000;
                  r_state     <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (r_bad) begin
                  r_err_cnt  <= sat_inc(r_err_cnt);
                  r_resp_msg <= resp_msg(r_hdr | 8'h80, 32'h0);
                  r_resp_len <= RESP_ACK_LEN;
                  r_state    <= ST_RESP;
               end else if (r_hdr[HDR_WRITE]) begin
                  r_resp_msg <= resp_msg(r_hdr, 32'h0);
                  r_resp_len <= RESP_ACK_LEN;
                  r_state    <= ST_RESP;
               end else begin
                  r_state    <= ST_RDWAIT;
               end
            end
            ST_RDWAIT: begin
               r_resp_msg <= resp_msg(r_hdr & 8'h7F, ram_rdata);
               r_resp_len <= RESP_RD_LEN;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               if (comm_writable) begin
                  r_wr_flag <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comm_mem_responder.sv
// Bench for comm_mem_responder: channel model, behavioural RAM and a
// scoreboard that checks every response the responder sends.
module tb_comm_mem_responder;

   localparam int MB = 72;
   localparam int AW = 17;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          comm_readable = 1'b0;
   logic [MB-1:0] comm_read_data = '0;
   logic [4:0]    comm_read_length = '0;
   logic          comm_read_flag;
   logic          comm_writable = 1'b1;
   logic          comm_write_flag;
   logic [MB-1:0] comm_write_data;
   logic [4:0]    comm_write_length;
   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic [7:0]    err_cnt;

   typedef struct { logic [MB-1:0] d; logic [4:0] len; } req_t;
   typedef struct { logic [MB-1:0] d; logic [4:0] len; int lat; } exp_t;

   req_t req_q[$];
   exp_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last_rf = 0;
   int n_rd    = 0;
   int n_wr    = 0;
   int n_ram_en = 0;
   logic prev_rst = 1'b1;

   logic [31:0] mem [0:(1<<AW)-1];

   comm_mem_responder #(.MESSAGE_BIT(MB), .ADDR_WIDTH(AW)) dut (
      .clk               (clk),
      .rst               (rst),
      .comm_readable     (comm_readable),
      .comm_read_data    (comm_read_data),
      .comm_read_length  (comm_read_length),
      .comm_read_flag    (comm_read_flag),
      .comm_writable     (comm_writable),
      .comm_write_flag   (comm_write_flag),
      .comm_write_data   (comm_write_data),
      .comm_write_length (comm_write_length),
      .ram_en            (ram_en),
      .ram_we            (ram_we),
      .ram_addr          (ram_addr),
      .ram_wdata         (ram_wdata),
      .ram_rdata         (ram_rdata),
      .err_cnt           (err_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural single-port RAM: byte enables, one-cycle read
   always @(posedge clk) begin
      if (ram_en) begin
         for (int k = 0; k < 4; k++)
            if (ram_we[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
         if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      end
   end

   // Channel read side: pop on consume, present head on the falling edge
   always @(posedge clk) begin
      if (comm_read_flag && req_q.size() != 0) void'(req_q.pop_front());
   end

   always @(negedge clk) begin
      comm_readable = (req_q.size() != 0);
      if (req_q.size() != 0) begin
         comm_read_data   = req_q[0].d;
         comm_read_length = req_q[0].len;
      end
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: protocol rules and scoreboard compare on each response
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (ram_en) n_ram_en++;
      if (rst || prev_rst) check("flags during/after reset", {comm_read_flag, comm_write_flag}, 0);
      prev_rst = rst;
      if (comm_read_flag || comm_write_flag)
         check("read/write flag exclusive", comm_read_flag & comm_write_flag, 0);
      if (comm_read_flag) begin
         n_rd++;
         last_rf = cyc;
      end
      if (comm_write_flag) begin
         n_wr++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected response: got %0h len %0d, expected none",
                     comm_write_data, comm_write_length);
         end else begin
            e = exp_q.pop_front();
            check("resp data", comm_write_data, e.d);
            check("resp len", comm_write_length, e.len);
            if (e.lat >= 0) check("latency", cyc - last_rf, e.lat);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [MB-1:0] mk(input logic [7:0] hdr, input logic [31:0] addr,
                                        input logic [31:0] wd);
      logic [MB-1:0] m;
      m = '0;
      m[7:0]   = hdr;
      m[39:8]  = addr;
      m[71:40] = wd;
      return m;
   endfunction

   task automatic send(input logic [7:0] hdr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] len, input logic [7:0] rhdr, input logic [31:0] rword,
                       input logic [4:0] rlen, input int lat);
      req_t r;
      exp_t e;
      r.d = mk(hdr, addr, wd);
      r.len = len;
      e.d = mk(rhdr, rword, 32'h0);
      e.len = rlen;
      e.lat = lat;
      exp_q.push_back(e);
      req_q.push_back(r);
   endtask

   task automatic send_noexp(input logic [7:0] hdr, input logic [31:0] addr, input logic [4:0] len);
      req_t r;
      r.d = mk(hdr, addr, 32'h0);
      r.len = len;
      req_q.push_back(r);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain within budget", exp_q.size(), 0);
      tick();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global timeout: got cycle %0d, expected completion", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int rd0, wr0, en0, n;
      repeat (3) tick();
      // Reset values
      check("reset write_data", comm_write_data, 0);
      check("reset write_length", comm_write_length, 0);
      check("reset err_cnt", err_cnt, 0);
      check("reset ram_en", ram_en, 0);
      check("reset ram_we", ram_we, 0);
      rst = 1'b0;
      tick();

      // Full write, then read back
      send(8'h1F, 32'h00000104, 32'hDEADBEEF, 5'd9, 8'h1F, 32'h0, 5'd1, 2);
      send(8'h00, 32'h00000104, 32'h0, 5'd5, 8'h00, 32'hDEADBEEF, 5'd5, 3);
      wait_drain(100);

      // Preload, partial write, readback, sel=0 write, readback
      send(8'h1F, 32'h00000104, 32'h11223344, 5'd9, 8'h1F, 32'h0, 5'd1, 2);
      send(8'h0B, 32'h00000104, 32'hAABBCCDD, 5'd9, 8'h0B, 32'h0, 5'd1, 2);
      send(8'h00, 32'h00000104, 32'h0, 5'd5, 8'h00, 32'h11BB33DD, 5'd5, 3);
      send(8'h01, 32'h00000104, 32'hFFFFFFFF, 5'd9, 8'h01, 32'h0, 5'd1, 2);
      send(8'h00, 32'h00000104, 32'h0, 5'd5, 8'h00, 32'h11BB33DD, 5'd5, 3);
      wait_drain(200);

      // Malformed: read header with length 7
      en0 = n_ram_en;
      send(8'h00, 32'h00000104, 32'h0, 5'd7, 8'h80, 32'h0, 5'd1, 2);
      wait_drain(100);
      check("err_cnt after one bad", err_cnt, 1);
      check("no ram_en on bad request", n_ram_en - en0, 0);

      // Saturation of the error counter
      for (int i = 0; i < 254; i++) begin
         if (i % 2 == 0) send(8'h01, 32'h0, 32'h0, 5'd5, 8'h81, 32'h0, 5'd1, 2);
         else            send(8'h80, 32'h0, 32'h0, 5'd5, 8'h80, 32'h0, 5'd1, 2);
      end
      wait_drain(3000);
      check("err_cnt at 255 bad", err_cnt, 255);
      send(8'h80, 32'h0, 32'h0, 5'd5, 8'h80, 32'h0, 5'd1, 2);
      wait_drain(100);
      check("err_cnt saturates", err_cnt, 255);
      check("no ram_en on bad requests", n_ram_en - en0, 0);

      // Backpressure: response held, second request not consumed
      comm_writable = 1'b0;
      rd0 = n_rd;
      wr0 = n_wr;
      send(8'h00, 32'h00000104, 32'h0, 5'd5, 8'h00, 32'h11BB33DD, 5'd5, -1);
      send(8'h20, 32'h00000104, 32'h0, 5'd5, 8'h20, 32'h11BB33DD, 5'd5, -1);
      repeat (8) tick();
      for (int i = 0; i < 12; i++) begin
         check("stall write_data stable", comm_write_data, mk(8'h00, 32'h11BB33DD, 32'h0));
         tick();
      end
      check("stall write_length", comm_write_length, 5);
      check("stall single consume", n_rd - rd0, 1);
      check("stall no write_flag", n_wr - wr0, 0);
      comm_writable = 1'b1;
      wait_drain(100);
      check("after release consumes", n_rd - rd0, 2);
      check("after release responses", n_wr - wr0, 2);

      // Aliasing: address bit 19 is beyond the RAM, port bit echoed
      send(8'h3F, 32'h00080000, 32'hCAFEF00D, 5'd9, 8'h3F, 32'h0, 5'd1, 2);
      send(8'h20, 32'h00000000, 32'h0, 5'd5, 8'h20, 32'hCAFEF00D, 5'd5, 3);
      wait_drain(100);

      // Reset while waiting on RAM read data
      wr0 = n_wr;
      send_noexp(8'h00, 32'h00000104, 5'd5);
      n = 0;
      while (!ram_en && n < 20) begin
         tick();
         n++;
      end
      check("reset test ram_en seen", ram_en, 1);
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      repeat (6) tick();
      check("no response after reset", n_wr - wr0, 0);
      check("err_cnt cleared by reset", err_cnt, 0);
      check("write_data cleared by reset", comm_write_data, 0);
      send(8'h00, 32'h00000104, 32'h0, 5'd5, 8'h00, 32'h11BB33DD, 5'd5, 3);
      wait_drain(100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
